multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for a multicycle RV32I datapath (lw, sw, R-type,
//   I-type ALU, beq and jal). It is a Moore machine. The only exceptions are
//   o_immSrc, which is decoded combinationally from the opcode, and o_pcWrite
//   in BEQ, which follows the ALU zero flag.
//
//   Optional feature: define MULTICYCLE_CONTROL_BNE_EN to make the BEQ state
//   also serve bne. The branch is taken on zero for funct3=000, on not-zero
//   for funct3=001, and never for any other funct3.
//
// Ports
//   i_clk         clock; state updates on the rising edge
//   i_arst_n      asynchronous active-low reset
//   i_op          opcode from the instruction register
//   i_funct3      IR[14:12]
//   i_funct7b5    IR[30]
//   i_zeroFlag    ALU zero flag, valid in the same cycle as o_aluOp
//   o_aluOp       ALU operation (ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5)
//   o_aluSrcA     00 PC, 01 oldPC, 10 rs1
//   o_aluSrcB     00 rs2, 01 immediate, 10 constant 4
//   o_resultSrc   00 ALUOut, 01 memory data, 10 ALU result
//   o_adrSrc      memory address select: 0 PC, 1 result
//   o_immSrc      immediate format: 00 I, 01 S, 10 B, 11 J
//   o_pcWrite, o_irWrite, o_regWrite, o_memWrite   write strobes
// ---------------------------------------------------------------------------
module multicycle_control (
   input  logic       i_clk,
   input  logic       i_arst_n,
   input  logic [6:0] i_op,
   input  logic [2:0] i_funct3,
   input  logic       i_funct7b5,
   input  logic       i_zeroFlag,
   output logic [3:0] o_aluOp,
   output logic [1:0] o_aluSrcA,
   output logic [1:0] o_aluSrcB,
   output logic [1:0] o_resultSrc,
   output logic       o_adrSrc,
   output logic [1:0] o_immSrc,
   output logic       o_pcWrite,
   output logic       o_irWrite,
   output logic       o_regWrite,
   output logic       o_memWrite
);

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
   } state_t;

   state_t state_q, state_d;

   logic pc_write, ir_write, reg_write, mem_write;
   logic br_take;

   // SUB is only meaningful for register-register ops: addi has no funct7,
   // so IR[30] belongs to the immediate there and must be ignored.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
      case (f3)
         3'b000:  alu_decode = sub_ok ? ALU_SUB : ALU_ADD;
         3'b010:  alu_decode = ALU_SLT;
         3'b100:  alu_decode = ALU_XOR;
         3'b110:  alu_decode = ALU_OR;
         3'b111:  alu_decode = ALU_AND;
         default: alu_decode = ALU_ADD;
      endcase
   endfunction

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) state_q <= S_FETCH;
      else           state_q <= state_d;
   end

   always_comb begin
`ifdef MULTICYCLE_CONTROL_BNE_EN
      case (i_funct3)
         3'b000:  br_take = i_zeroFlag;
         3'b001:  br_take = ~i_zeroFlag;
         default: br_take = 1'b0;
      endcase
`else
      br_take = i_zeroFlag;
`endif
   end

   always_comb begin
      case (i_op)
         OP_STORE:  o_immSrc = 2'b01;
         OP_BRANCH: o_immSrc = 2'b10;
         OP_JAL:    o_immSrc = 2'b11;
         default:   o_immSrc = 2'b00;
      endcase
   end

   always_comb begin
      state_d     = S_FETCH;
      o_aluOp     = ALU_ADD;
      o_aluSrcA   = 2'b00;
      o_aluSrcB   = 2'b00;
      o_resultSrc = 2'b00;
      o_adrSrc    = 1'b0;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write    = 1'b1;
            o_aluSrcB   = 2'b10;
            o_resultSrc = 2'b10;
            pc_write    = 1'b1;
            state_d     = S_DECODE;
         end
         S_DECODE: begin
            // Branch/jump target PC+imm is formed here while the opcode is decoded.
            o_aluSrcA = 2'b01;
            o_aluSrcB = 2'b01;
            case (i_op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            o_aluSrcA = 2'b10;
            o_aluSrcB = 2'b01;
            state_d   = (i_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            o_adrSrc = 1'b1;
            state_d  = S_MEMWB;
         end
         S_MEMWB: begin
            o_resultSrc = 2'b01;
            reg_write   = 1'b1;
         end
         S_MEMWRITE: begin
            o_adrSrc  = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTER: begin
            o_aluSrcA = 2'b10;
            o_aluOp   = alu_decode(i_funct3, i_funct7b5);
            state_d   = S_ALUWB;
         end
         S_EXECUTEI: begin
            o_aluSrcA = 2'b10;
            o_aluSrcB = 2'b01;
            o_aluOp   = alu_decode(i_funct3, 1'b0);
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
         end
         S_BEQ: begin
            o_aluSrcA = 2'b10;
            o_aluOp   = ALU_SUB;
            pc_write  = br_take;
         end
         S_JAL: begin
            // PC <= oldPC+imm (from ALUOut); this cycle forms rd = oldPC+4.
            o_aluSrcA = 2'b01;
            o_aluSrcB = 2'b10;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Reset holds state at FETCH, but FETCH's strobes must stay quiet until release.
   assign o_pcWrite  = pc_write  & i_arst_n;
   assign o_irWrite  = ir_write  & i_arst_n;
   assign o_regWrite = reg_write & i_arst_n;
   assign o_memWrite = mem_write & i_arst_n;

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. Each instruction is expanded
//   into its expected per-cycle control vectors from the instruction class.
//   A single compare process checks the DUT on every falling clock edge.
//   Directed instructions come first, including a reset in mid-instruction.
//   Randomized instructions follow.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2,
                          A_OR = 4'd3, A_XOR = 4'd4, A_SLT = 4'd5;

`ifdef MULTICYCLE_CONTROL_BNE_EN
   localparam bit BNE_EN = 1'b1;
`else
   localparam bit BNE_EN = 1'b0;
`endif

   logic       clk, rst_n;
   logic [6:0] op;
   logic [2:0] f3;
   logic       f7, zf;
   logic [3:0] alu_op;
   logic [1:0] src_a, src_b, res_src, imm_src;
   logic       adr_src, pc_w, ir_w, reg_w, mem_w;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic        chk_en;
   logic [14:0] exp_cur;
   logic [14:0] exp_q[$];

   multicycle_control dut (
      .i_clk(clk), .i_arst_n(rst_n), .i_op(op), .i_funct3(f3),
      .i_funct7b5(f7), .i_zeroFlag(zf), .o_aluOp(alu_op),
      .o_aluSrcA(src_a), .o_aluSrcB(src_b), .o_resultSrc(res_src),
      .o_adrSrc(adr_src), .o_immSrc(imm_src), .o_pcWrite(pc_w),
      .o_irWrite(ir_w), .o_regWrite(reg_w), .o_memWrite(mem_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] mk(input logic [3:0] a, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] rs,
                                      input logic adr, input logic pc, input logic ir,
                                      input logic rw, input logic mw);
      return {a, sa, sb, rs, adr, pc, ir, rw, mw};
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      if (o == 7'b0100011) return 2'b01;
      if (o == 7'b1100011) return 2'b10;
      if (o == 7'b1101111) return 2'b11;
      return 2'b00;
   endfunction

   function automatic logic [3:0] alu_of(input logic [2:0] f, input logic sub_ok);
      if (f == 3'b000) return sub_ok ? A_SUB : A_ADD;
      if (f == 3'b010) return A_SLT;
      if (f == 3'b100) return A_XOR;
      if (f == 3'b110) return A_OR;
      if (f == 3'b111) return A_AND;
      return A_ADD;
   endfunction

   // Expected control vectors for one instruction, one entry per cycle.
   task automatic build(input logic [6:0] o, input logic [2:0] f, input logic s, input logic z);
      logic [14:0] fe, de, aw, ma;
      logic take;
      fe = mk(A_ADD, 2'b00, 2'b10, 2'b10, 0, 1, 1, 0, 0);
      de = mk(A_ADD, 2'b01, 2'b01, 2'b00, 0, 0, 0, 0, 0);
      aw = mk(A_ADD, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0);
      ma = mk(A_ADD, 2'b10, 2'b01, 2'b00, 0, 0, 0, 0, 0);
      exp_q = {fe, de};
      case (o)
         7'b0000011: exp_q = {exp_q, ma, mk(A_ADD, 0, 0, 0, 1, 0, 0, 0, 0),
                                         mk(A_ADD, 0, 0, 2'b01, 0, 0, 0, 1, 0)};
         7'b0100011: exp_q = {exp_q, ma, mk(A_ADD, 0, 0, 0, 1, 0, 0, 0, 1)};
         7'b0110011: exp_q = {exp_q, mk(alu_of(f, s), 2'b10, 2'b00, 0, 0, 0, 0, 0, 0), aw};
         7'b0010011: exp_q = {exp_q, mk(alu_of(f, 1'b0), 2'b10, 2'b01, 0, 0, 0, 0, 0, 0), aw};
         7'b1100011: begin
            if (BNE_EN) take = (f == 3'b000) ? z : (f == 3'b001) ? ~z : 1'b0;
            else        take = z;
            exp_q = {exp_q, mk(A_SUB, 2'b10, 2'b00, 0, 0, take, 0, 0, 0)};
         end
         7'b1101111: exp_q = {exp_q, mk(A_ADD, 2'b01, 2'b10, 0, 0, 1, 0, 0, 0), aw};
         default: ;
      endcase
   endtask

   task automatic check(input string name, input int got, input int expv);
      checks++;
      if (got != expv) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, expv);
      end
   endtask

   // Runs expected-vector indices [first, last); called at posedge+1.
   task automatic run(input logic [6:0] o, input logic [2:0] f, input logic s,
                      input logic z, input int first, input int last);
      if (first == 0) begin
         op = o; f3 = f; f7 = s; zf = z;
         build(o, f, s, z);
      end
      for (int k = first; k < last && k < exp_q.size(); k++) begin
         exp_cur = exp_q[k];
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (chk_en) begin
         check("ctrl", {alu_op, src_a, src_b, res_src, adr_src, pc_w, ir_w, reg_w, mem_w},
               exp_cur);
         check("imm_src", imm_src, imm_of(op));
      end
   end

   initial begin
      logic [6:0] o;
      int sel;
      chk_en = 1'b0;
      op = 7'b0110011; f3 = 3'b000; f7 = 1'b0; zf = 1'b0;
      exp_cur = mk(A_ADD, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("first_irwrite", ir_w, 1);
      check("first_pcwrite", pc_w, 1);

      // lw: regWrite and resultSrc=01 appear only in cycle 5
      run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 4);
      check("lw_c5_regw", reg_w, 1);
      check("lw_c5_ressrc", res_src, 2'b01);
      run(7'b0000011, 3'b010, 1'b0, 1'b0, 4, 5);
      check("lw_next_fetch", ir_w, 1);

      run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 9);
      // R-type SUB vs I-type ADD with identical funct fields
      run(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 2);
      check("r_sub", alu_op, 4'd1);
      run(7'b0110011, 3'b000, 1'b1, 1'b0, 2, 9);
      run(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 2);
      check("i_add", alu_op, 4'd0);
      run(7'b0010011, 3'b000, 1'b1, 1'b0, 2, 9);

      // beq taken / not taken, FETCH again at cycle 4
      run(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 2);
      check("beq_taken", pc_w, 1);
      run(7'b1100011, 3'b000, 1'b0, 1'b1, 2, 9);
      check("beq_c4_fetch", ir_w, 1);
      run(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 2);
      check("beq_not_taken", pc_w, 0);
      run(7'b1100011, 3'b000, 1'b0, 1'b0, 2, 9);

      // bne encoding with zero clear
      run(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 2);
      check("bne_pcwrite", pc_w, BNE_EN ? 1 : 0);
      run(7'b1100011, 3'b001, 1'b0, 1'b0, 2, 9);

      // jal: pcWrite in JAL, regWrite in ALUWB, FETCH at cycle 5
      run(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 2);
      check("jal_pcwrite", pc_w, 1);
      run(7'b1101111, 3'b000, 1'b0, 1'b0, 2, 3);
      check("jal_aluwb_regw", reg_w, 1);
      run(7'b1101111, 3'b000, 1'b0, 1'b0, 3, 9);
      check("jal_c5_fetch", ir_w, 1);

      run(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 9);

      // reset asserted while in MEMREAD
      run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
      check("memread_adrsrc", adr_src, 1);
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_adrsrc", adr_src, 0);
      check("rst_ressrc", res_src, 2'b10);
      check("rst_strobes", {pc_w, ir_w, reg_w, mem_w}, 0);
      exp_cur = mk(A_ADD, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rst_release_irwrite", ir_w, 1);

      // randomized instruction stream
      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 6);
         case (sel)
            0: o = 7'b0000011;
            1: o = 7'b0100011;
            2: o = 7'b0110011;
            3: o = 7'b0010011;
            4: o = 7'b1100011;
            5: o = 7'b1101111;
            default: begin
               o = 7'($urandom);
               while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                      o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111)
                  o = 7'($urandom);
            end
         endcase
         run(o, 3'($urandom), 1'($urandom), 1'($urandom), 0, 9);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
